ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Front-end input stage for the player controller. It receives PS/2 keyboard frames, decodes make, break and extended scan codes, and drives the held-key vector keydown[4:0].
- The player FSM consumes keydown directly every clock. The block also reports per-key change events and frame errors for debug LEDs.

Parameters:
- FILTER_LEN, 8: consecutive equal clk samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge, mid-frame, before the frame is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous.
- ps2_data  input  1  raw PS/2 data, asynchronous.
- keydown  output  5  held keys: bit0 up, bit1 left, bit2 right, bit3 down, bit4 jump.
- key_event  output  1  one-cycle pulse when any keydown bit changes.
- frame_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Behaviour:
- Reset: synchronous on clk while rst=1.
  - keydown=0, key_event=0, frame_err=0.
  - Receiver returns to RX_IDLE; bit counter and timeout counter are 0.
  - Filtered clock is set to 1. ext and brk flags are cleared.
  - rst mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops.
- Filter: filtered ps2_clk takes the synced level only after FILTER_LEN consecutive identical samples. A filtered 1->0 transition is a "fall", one cycle wide, and samples the synced ps2_data.
- Receiver FSM, one action per fall:
  - RX_IDLE: data=0 goes to RX_DATA with bit count 0. data=1 is a bad start bit; stay in RX_IDLE with no error.
  - RX_DATA: shift data in LSB first. After the 8th bit go to RX_PARITY.
  - RX_PARITY: capture parity; go to RX_STOP.
  - RX_STOP:
    - If stop=1 and the 9 bits have odd parity, byte_valid pulses the next cycle.
    - Otherwise frame_err pulses and ext/brk are cleared.
    - In both cases return to RX_IDLE.
- Timeout: the counter clears on every fall and holds 0 in RX_IDLE. When it reaches TIMEOUT_CYCLES-1 outside RX_IDLE: frame_err pulses, the FSM goes to RX_IDLE, and keydown is unchanged.
- Decoder, on byte_valid:
  - 0xE0 sets ext. 0xF0 sets brk. Neither byte changes keydown.
  - Any other byte is looked up with ext, then ext and brk are cleared:
    - ext=1: 0x75 maps to up, 0x6B to left, 0x74 to right, 0x72 to down.
    - ext=0: 0x29 (space) maps to jump.
    - All other codes, including 0xAA, 0xFA, 0xFE and non-extended 0x75/0x6B/0x74/0x72 (keypad), are ignored.
  - A mapped code sets keydown[bit] to NOT brk.
  - key_event pulses in the same cycle as the keydown update, only if the bit value actually changed. Typematic repeats of a held key produce no event.
- Latency: the fall that samples the stop bit is cycle N; byte_valid is at N+1; keydown and key_event are visible at N+2.
- Simultaneous keys:
  - Any combination may be held. Left and right both 1 is legal; the consumer prioritises left.
  - One key changes per byte, so key_event is never asserted for two bits in one cycle.
- frame_err and key_event are mutually exclusive in any cycle.

Decomposition:
- Shared package (input_pkg):
  - Scan-code constants SC_EXT=0xE0, SC_BRK=0xF0, SC_UP, SC_LEFT, SC_RIGHT, SC_DOWN, SC_SPACE.
  - Key bit indices KEY_UP=0, KEY_LEFT=1, KEY_RIGHT=2, KEY_DOWN=3, KEY_JUMP=4.
  - Receiver state encoding.
- Sub-module ps2_rx contains the synchronisers, filter, receiver FSM and timeout, and outputs rx_byte[7:0], byte_valid and frame_err.
- The top level holds the ext/brk flags, the lookup and the keydown register.

Test Plan:
- Send E0,75 -> keydown=5'b00001 at N+2 after the 75 stop bit; key_event pulses exactly once. Then send E0,F0,75 -> keydown=5'b00000 and one key_event.
- Send 29,29,29 (typematic) -> keydown[4]=1 after the first byte; exactly one key_event in total; F0,29 -> keydown[4]=0.
- Send E0,6B then E0,74 -> keydown=5'b00110. Send bare 6B -> keydown unchanged and no key_event.
- Send E0, then 6B with bad parity -> frame_err pulses once and keydown is unchanged. Then send 74 (ext cleared) -> no change.
- Inject a ps2_clk low glitch of FILTER_LEN-1 cycles mid-frame -> no bit is shifted and the frame decodes correctly. Stop a frame after 5 bits for TIMEOUT_CYCLES cycles -> frame_err pulses; the next E0,72 gives keydown[3]=1.
- Hold keydown=5'b10001, then assert rst for 1 cycle mid-frame -> keydown=0 next cycle with no key_event. A following E0,75 decodes to 5'b00001.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the PS/2 key decoder: scan-code constants, held-key
// bit indices, receiver state encoding and the scan-code-to-key lookup.
// -----------------------------------------------------------------------------
package input_pkg;

    // Scan codes (set 2)
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Bit positions inside keydown
    localparam int         NUM_KEYS  = 5;
    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_LEFT  = 3'd1;
    localparam logic [2:0] KEY_RIGHT = 3'd2;
    localparam logic [2:0] KEY_DOWN  = 3'd3;
    localparam logic [2:0] KEY_JUMP  = 3'd4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    // Arrow keys only exist as extended codes; the bare codes are keypad keys
    // and must not move the player.
    function automatic key_map_t map_code(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = KEY_UP;
        if (ext) begin
            case (code)
                SC_UP:    m.idx = KEY_UP;
                SC_LEFT:  m.idx = KEY_LEFT;
                SC_RIGHT: m.idx = KEY_RIGHT;
                SC_DOWN:  m.idx = KEY_DOWN;
                default:  m.hit = 1'b0;
            endcase
        end else if (code == SC_SPACE) begin
            m.idx = KEY_JUMP;
        end else begin
            m.hit = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder_if
// Bundles the raw PS/2 lines and the decoded key outputs.
//   ps2_clk, ps2_data : raw PS/2 lines (driven by the keyboard side)
//   keydown[4:0]      : held keys (up, left, right, down, jump)
//   key_event         : one-cycle pulse on any keydown change
//   frame_err         : one-cycle pulse on parity/stop/timeout error
// master = keyboard side, slave = decoder.
// -----------------------------------------------------------------------------
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] keydown;
    logic       key_event;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  keydown, key_event, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keydown, key_event, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 byte receiver: 2-flop synchronisers, ps2_clk glitch filter, frame FSM
// and mid-frame timeout.
//   clk, rst        : system clock, synchronous active-high reset
//   ps2_clk_i       : raw PS/2 clock (asynchronous)
//   ps2_data_i      : raw PS/2 data (asynchronous)
//   rx_byte_o[7:0]  : last received byte, valid while byte_valid_o is high
//   byte_valid_o    : one-cycle pulse, cycle after the stop-bit fall
//   frame_err_o     : one-cycle pulse on parity/stop error or timeout
// -----------------------------------------------------------------------------
module ps2_rx
    import input_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    logic [1:0]     clk_sync_q, data_sync_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    rx_state_e      state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TW-1:0]  timeout_q, timeout_d;
    logic           byte_valid_q, byte_valid_d;
    logic           frame_err_q, frame_err_d;

    logic clk_synced, data_synced, fall;

    assign clk_synced  = clk_sync_q[1];
    assign data_synced = data_sync_q[1];

    // Filtered clock flips on the FILTER_LEN-th consecutive sample that
    // differs from it; any agreeing sample restarts the count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_synced != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_synced;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        timeout_d    = (state_q == RX_IDLE || fall) ? '0 : timeout_q + 1'b1;

        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    // A high start bit is line noise; stay idle silently.
                    if (!data_synced) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d = {data_synced, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
                RX_PARITY: begin
                    parity_d = data_synced;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    if (data_synced && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                    else                                        frame_err_d  = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE && timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_d = 1'b1;
            state_d     = RX_IDLE;
            timeout_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            timeout_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value, independent of statement order.
            clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q  <= {data_sync_q[0], ps2_data_i};
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte_o    = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder
// Turns PS/2 make/break/extended scan codes into a held-key vector.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : ps2_key_decoder_if.slave (ps2_clk, ps2_data in;
//              keydown, key_event, frame_err out)
// -----------------------------------------------------------------------------
module ps2_key_decoder
    import input_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    ps2_key_decoder_if.slave    bus
);

    logic [7:0]          rx_byte;
    logic                byte_valid;
    logic                rx_err;

    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [NUM_KEYS-1:0] keydown_q, keydown_d;
    logic                key_event_q, key_event_d;
    key_map_t            map;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (rx_err)
    );

    assign map = map_code(rx_byte, ext_q);

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        keydown_d   = keydown_q;
        key_event_d = 1'b0;
        if (rx_err) begin
            // A corrupted frame may have been the code the prefixes belonged to.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (map.hit) keydown_d[map.idx] = ~brk_q;
                // Typematic repeats rewrite the same value and stay silent.
                key_event_d = (keydown_d != keydown_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keydown_q   <= '0;
            key_event_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keydown_q   <= keydown_d;
            key_event_q <= key_event_d;
        end
    end

    assign bus.keydown   = keydown_q;
    assign bus.key_event = key_event_q;
    assign bus.frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder: drives PS/2 frames through the
// interface and compares keydown and event/error pulse counts against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_ps2_key_decoder;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 50000;
    localparam int HALF           = 12;   // PS/2 half-period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int ev_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int exp_ev   = 0;
    int exp_fe   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.key_event === 1'b1) ev_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.key_event === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame bit i (0 = start .. 10 = stop); parity is odd unless bad is set.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        idle(HALF);
        bus.ps2_clk = 1'b0;
        idle(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    // glitch_at >= 0 inserts a FILTER_LEN-1 cycle low pulse before that bit.
    task automatic send_frame(input logic [7:0] b, input logic bad = 1'b0,
                              input int glitch_at = -1);
        logic [10:0] f;
        f = frame_bits(b, bad);
        for (int i = 0; i < 11; i++) begin
            if (i == glitch_at) begin
                idle(HALF);
                bus.ps2_clk = 1'b0;
                idle(FILTER_LEN - 1);
                bus.ps2_clk = 1'b1;
            end
            send_bit(f[i]);
        end
        idle(30);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        logic [10:0] f;
        f = frame_bits(b, 1'b0);
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    // Raw stop-bit fall at a negedge: 2 sync edges + FILTER_LEN samples puts
    // the filtered fall in the cycle before the 10th posedge (N); keydown is
    // registered at the 11th posedge (N+2).
    task automatic send_latency(input logic [7:0] b, input logic [4:0] kd_old,
                                input logic [4:0] kd_new);
        logic [10:0] f;
        f = frame_bits(b, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        bus.ps2_data = 1'b1;
        idle(HALF);
        bus.ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("lat_n1_keydown", 32'(bus.keydown), 32'(kd_old));
        @(negedge clk);
        check("lat_n2_keydown", 32'(bus.keydown), 32'(kd_new));
        check("lat_n2_event", 32'(bus.key_event), 32'd1);
        idle(HALF);
        bus.ps2_clk = 1'b1;
        idle(30);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst          = 1'b1;
        idle(3);
        check("rst_keydown", 32'(bus.keydown), 32'd0);
        check("rst_event", 32'(bus.key_event), 32'd0);
        check("rst_err", 32'(bus.frame_err), 32'd0);
        rst = 1'b0;
        idle(20);

        // Up press with exact latency, then release
        send_frame(8'hE0);
        send_latency(8'h75, 5'b00000, 5'b00001);
        exp_ev++;
        check("up_make_events", ev_cnt, exp_ev);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        exp_ev++;
        check("up_break_keydown", 32'(bus.keydown), 32'b00000);
        check("up_break_events", ev_cnt, exp_ev);

        // Typematic space
        send_frame(8'h29);
        check("space_first", 32'(bus.keydown), 32'b10000);
        send_frame(8'h29); send_frame(8'h29);
        exp_ev++;
        check("space_repeat_events", ev_cnt, exp_ev);
        send_frame(8'hF0); send_frame(8'h29);
        exp_ev++;
        check("space_break", 32'(bus.keydown), 32'b00000);
        check("space_break_events", ev_cnt, exp_ev);

        // Left + right held together; bare keypad 6B ignored
        send_frame(8'hE0); send_frame(8'h6B);
        send_frame(8'hE0); send_frame(8'h74);
        exp_ev += 2;
        check("left_right", 32'(bus.keydown), 32'b00110);
        send_frame(8'h6B);
        check("keypad_ignored", 32'(bus.keydown), 32'b00110);
        check("keypad_events", ev_cnt, exp_ev);

        // Parity error clears ext; following 74 is non-extended
        send_frame(8'hE0);
        send_frame(8'h6B, 1'b1);
        exp_fe++;
        check("parity_err", fe_cnt, exp_fe);
        check("parity_keydown", 32'(bus.keydown), 32'b00110);
        send_frame(8'h74);
        check("after_err_keydown", 32'(bus.keydown), 32'b00110);
        check("after_err_events", ev_cnt, exp_ev);

        // Short ps2_clk glitch mid-frame is filtered out
        send_frame(8'hE0);
        send_frame(8'h75, 1'b0, 4);
        exp_ev++;
        check("glitch_keydown", 32'(bus.keydown), 32'b00111);
        check("glitch_err", fe_cnt, exp_fe);

        // Timeout after 5 bits
        send_partial(8'h72, 5);
        for (int i = 0; i < TIMEOUT_CYCLES + 200 && fe_cnt == exp_fe; i++) @(negedge clk);
        exp_fe++;
        check("timeout_err", fe_cnt, exp_fe);
        check("timeout_keydown", 32'(bus.keydown), 32'b00111);
        idle(20);
        send_frame(8'hE0); send_frame(8'h72);
        exp_ev++;
        check("down_after_timeout", 32'(bus.keydown), 32'b01111);

        // Reach 10001 then reset mid-frame
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h74);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h72);
        send_frame(8'h29);
        exp_ev += 4;
        check("hold_10001", 32'(bus.keydown), 32'b10001);
        check("hold_events", ev_cnt, exp_ev);
        send_partial(8'h75, 4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_keydown", 32'(bus.keydown), 32'd0);
        check("midrst_event", 32'(bus.key_event), 32'd0);
        rst = 1'b0;
        idle(30);
        check("midrst_events", ev_cnt, exp_ev);
        send_frame(8'hE0); send_frame(8'h75);
        exp_ev++;
        check("post_rst_up", 32'(bus.keydown), 32'b00001);
        check("final_events", ev_cnt, exp_ev);
        check("final_errs", fe_cnt, exp_fe);
        check("event_err_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
